// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: converts the data cache's native read/write request interface into an AXI4 master
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_rd_* / o_rd_rdy          cache read request (type 000 byte, 001 half, 010 word, 100 line)
//   o_ret_*                    read return beats; o_ret_last = {error, last}
//   i_wr_* / o_wr_rdy          cache write request with 128-bit line data and byte strobe
//   AR/R, AW/W/B channels      AXI4 master, one outstanding read and one outstanding write
//
// Build option: define BRIDGE_RAW_CHECK_EN to block only reads that hit the line of a
// pending write; otherwise every read waits until the write path is idle.
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         o_rd_rdy,
  output logic         o_ret_valid,
  output logic [1:0]   o_ret_last,
  output logic [31:0]  o_ret_data,
  input  logic         i_wr_req,
  input  logic [2:0]   i_wr_type,
  input  logic [31:0]  i_wr_addr,
  input  logic [3:0]   i_wr_wstrb,
  input  logic [127:0] i_wr_data,
  output logic         o_wr_rdy,
  output logic [3:0]   o_arid,
  output logic [31:0]  o_araddr,
  output logic [7:0]   o_arlen,
  output logic [2:0]   o_arsize,
  output logic [1:0]   o_arburst,
  output logic         o_arvalid,
  input  logic         i_arready,
  input  logic [3:0]   i_rid,
  input  logic [31:0]  i_rdata,
  input  logic [1:0]   i_rresp,
  input  logic         i_rlast,
  input  logic         i_rvalid,
  output logic         o_rready,
  output logic [3:0]   o_awid,
  output logic [31:0]  o_awaddr,
  output logic [7:0]   o_awlen,
  output logic [2:0]   o_awsize,
  output logic [1:0]   o_awburst,
  output logic         o_awvalid,
  input  logic         i_awready,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  output logic         o_wlast,
  output logic         o_wvalid,
  input  logic         i_wready,
  input  logic [3:0]   i_bid,
  input  logic [1:0]   i_bresp,
  input  logic         i_bvalid,
  output logic         o_bready
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;
  rstate_t        r_rstate;
  wstate_t        r_wstate;
  logic           r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic [31:0]    r_araddr, r_awaddr;
  logic [7:0]     r_arlen, r_awlen;
  logic [2:0]     r_arsize, r_awsize;
  logic [3:0]     r_wstrb;
  logic [127:0]   r_wdata;
  logic [1:0]     r_beat;
  logic           w_rline, w_wline, w_wr_acc, w_hazard, w_aw_ok, w_w_ok;
  logic           w_unused;
  assign w_rline  = i_rd_type == 3'b100;
  assign w_wline  = i_wr_type == 3'b100;
  assign w_wr_acc = i_wr_req && o_wr_rdy;
`ifdef BRIDGE_RAW_CHECK_EN
  assign w_hazard = (r_wstate != W_IDLE && i_rd_addr[31:4] == r_awaddr[31:4]) ||
                    (w_wr_acc && i_rd_addr[31:4] == i_wr_addr[31:4]);
`else
  assign w_hazard = (r_wstate != W_IDLE) || w_wr_acc;
`endif
  assign o_rd_rdy    = r_rstate == R_IDLE && !w_hazard;
  assign o_wr_rdy    = r_wstate == W_IDLE;
  assign o_ret_valid = r_rready && i_rvalid;
  assign o_ret_last  = r_rready ? {i_rresp != 2'b00, i_rlast} : 2'b00;
  assign o_ret_data  = i_rdata;
  assign o_arid      = RD_ID;
  assign o_araddr    = r_araddr;
  assign o_arlen     = r_arlen;
  assign o_arsize    = r_arsize;
  assign o_arburst   = 2'b01;
  assign o_arvalid   = r_arvalid;
  assign o_rready    = r_rready;
  assign o_awid      = WR_ID;
  assign o_awaddr    = r_awaddr;
  assign o_awlen     = r_awlen;
  assign o_awsize    = r_awsize;
  assign o_awburst   = 2'b01;
  assign o_awvalid   = r_awvalid;
  assign o_wdata     = r_wdata[32*r_beat +: 32];
  assign o_wstrb     = r_wstrb;
  assign o_wlast     = {6'd0, r_beat} == r_awlen;
  assign o_wvalid    = r_wvalid;
  assign o_bready    = r_bready;
  // AW and the final W beat may complete in either order or together
  assign w_aw_ok  = !r_awvalid || i_awready;
  assign w_w_ok   = !r_wvalid || (i_wready && o_wlast);
  assign w_unused = ^{i_rid, i_bid, i_bresp};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (i_rd_req && o_rd_rdy) begin
          r_rstate  <= R_ADDR;
          r_arvalid <= 1'b1;
          r_araddr  <= w_rline ? {i_rd_addr[31:4], 4'h0} : i_rd_addr;
          r_arlen   <= w_rline ? 8'd3 : 8'd0;
          r_arsize  <= w_rline ? 3'd2 : {1'b0, i_rd_type[1:0]};
        end
        R_ADDR: if (i_arready) begin
          r_rstate  <= R_DATA;
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
        end
        R_DATA: if (i_rvalid && i_rlast) begin
          r_rstate <= R_IDLE;
          r_rready <= 1'b0;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_beat    <= 2'd0;
    end else begin
      case (r_wstate)
        W_IDLE: if (i_wr_req) begin
          r_wstate  <= W_REQ;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_beat    <= 2'd0;
          r_awaddr  <= w_wline ? {i_wr_addr[31:4], 4'h0} : i_wr_addr;
          r_awlen   <= w_wline ? 8'd3 : 8'd0;
          r_awsize  <= w_wline ? 3'd2 : {1'b0, i_wr_type[1:0]};
          r_wstrb   <= w_wline ? 4'hF : i_wr_wstrb;
          r_wdata   <= i_wr_data;
        end
        W_REQ: begin
          if (i_awready) r_awvalid <= 1'b0;
          if (r_wvalid && i_wready) begin
            r_beat <= r_beat + 2'd1;
            if (o_wlast) r_wvalid <= 1'b0;
          end
          if (w_aw_ok && w_w_ok) begin
            r_wstate <= W_RESP;
            r_bready <= 1'b1;
          end
        end
        W_RESP: if (i_bvalid) begin
          r_wstate <= W_IDLE;
          r_bready <= 1'b0;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: directed vectors for cache_axi_bridge with a hand-driven AXI slave
module tb_cache_axi_bridge;
`ifdef BRIDGE_RAW_CHECK_EN
  localparam logic RAW = 1'b1;
`else
  localparam logic RAW = 1'b0;
`endif
  logic clk = 1'b0, rst_n;
  logic i_rd_req, i_wr_req, i_arready, i_rlast, i_rvalid, i_awready, i_wready, i_bvalid;
  logic [2:0] i_rd_type, i_wr_type;
  logic [31:0] i_rd_addr, i_wr_addr, i_rdata;
  logic [3:0] i_wr_wstrb, i_rid, i_bid;
  logic [127:0] i_wr_data;
  logic [1:0] i_rresp, i_bresp;
  logic o_rd_rdy, o_ret_valid, o_wr_rdy, o_arvalid, o_rready, o_awvalid, o_wlast, o_wvalid, o_bready;
  logic [1:0] o_ret_last, o_arburst, o_awburst;
  logic [31:0] o_ret_data, o_araddr, o_awaddr, o_wdata;
  logic [3:0] o_arid, o_awid, o_wstrb;
  logic [7:0] o_arlen, o_awlen;
  logic [2:0] o_arsize, o_awsize;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  cache_axi_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .o_rd_rdy(o_rd_rdy),
    .o_ret_valid(o_ret_valid), .o_ret_last(o_ret_last), .o_ret_data(o_ret_data),
    .i_wr_req(i_wr_req), .i_wr_type(i_wr_type), .i_wr_addr(i_wr_addr), .i_wr_wstrb(i_wr_wstrb),
    .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a, input logic [2:0] t);
    i_rd_req = 1'b1; i_rd_type = t; i_rd_addr = a;
    #1;
    check("rd_rdy", o_rd_rdy, 1'b1);
    tick;
    i_rd_req = 1'b0;
  endtask
  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input int dly);
    check("arvalid", o_arvalid, 1'b1);
    check("araddr", o_araddr, a);
    check("arlen", o_arlen, len);
    check("arsize", o_arsize, sz);
    check("arburst", o_arburst, 2'b01);
    check("arid", o_arid, 4'd0);
    for (int i = 0; i < dly; i++) begin
      tick;
      check("ar_hold", {o_arvalid, o_araddr}, {1'b1, a});
    end
    i_arready = 1'b1;
    tick;
    i_arready = 1'b0;
    check("ar_done", {o_arvalid, o_rready}, 2'b01);
  endtask
  task automatic r_beats(input int n, input int err, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      i_rvalid = 1'b0;
      #1;
      check("ret_gap", {o_ret_valid, o_rready}, 2'b01);
      tick;
      i_rvalid = 1'b1; i_rdata = base + i; i_rlast = (i == n - 1); i_rresp = (i == err) ? 2'b10 : 2'b00;
      #1;
      check("ret_valid", o_ret_valid, 1'b1);
      check("ret_data", o_ret_data, base + i);
      check("ret_last", o_ret_last, {i == err, i == n - 1});
      tick;
    end
    i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
    #1;
    check("r_end", {o_rready, o_ret_valid, o_rd_rdy}, 3'b001);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    {i_rd_req, i_wr_req, i_arready, i_rlast, i_rvalid, i_awready, i_wready, i_bvalid} = '0;
    i_rd_type = 3'd0; i_wr_type = 3'd0; i_rd_addr = '0; i_wr_addr = '0; i_rdata = '0;
    i_wr_wstrb = '0; i_rid = 4'd0; i_bid = 4'd1; i_rresp = '0; i_bresp = '0;
    i_wr_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11223344};
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_valids", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_ret_valid}, 6'd0);
    check("rst_ret_last", o_ret_last, 2'b00);
    check("rst_rdy", {o_rd_rdy, o_wr_rdy}, 2'b11);
    // word read
    rd(32'h0000_1004, 3'b010);
    ar_phase(32'h0000_1004, 8'd0, 3'd2, 2);
    r_beats(1, 9, 32'hDEADBEEF);
    // line read with gaps
    rd(32'h0000_2038, 3'b100);
    ar_phase(32'h0000_2030, 8'd3, 3'd2, 0);
    r_beats(4, 9, 32'hA0000000);
    // line read with error on beat 2
    rd(32'h0000_5014, 3'b100);
    ar_phase(32'h0000_5010, 8'd3, 3'd2, 1);
    r_beats(4, 1, 32'hB0000000);
    // line write, AW late
    i_wr_req = 1'b1; i_wr_type = 3'b100; i_wr_addr = 32'h1000_0048; i_wr_wstrb = 4'h0;
    #1;
    check("wr_rdy", o_wr_rdy, 1'b1);
    tick;
    i_wr_req = 1'b0;
    check("aw_fields", {o_awvalid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awid}, {1'b1, 32'h1000_0040, 8'd3, 3'd2, 2'b01, 4'd1});
    i_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("w_beat", {o_wvalid, o_wdata, o_wstrb, o_wlast}, {1'b1, i_wr_data[32*i +: 32], 4'hF, i == 3});
      tick;
    end
    i_wready = 1'b0;
    check("w_done", {o_wvalid, o_awvalid, o_bready, o_wr_rdy}, 4'b0100);
    repeat (5) tick;
    check("aw_hold", {o_awvalid, o_awaddr}, {1'b1, 32'h1000_0040});
    i_awready = 1'b1;
    tick;
    i_awready = 1'b0;
    check("w_resp", {o_awvalid, o_bready, o_wr_rdy}, 3'b010);
    i_bvalid = 1'b1;
    tick;
    i_bvalid = 1'b0;
    check("b_done", {o_bready, o_wr_rdy}, 2'b01);
    // byte write with same-cycle line read to the same line
    i_rd_req = 1'b1; i_rd_type = 3'b100; i_rd_addr = 32'h0000_0100;
    i_wr_req = 1'b1; i_wr_type = 3'b000; i_wr_addr = 32'h0000_0103; i_wr_wstrb = 4'b1000;
    #1;
    check("same_cycle", {o_rd_rdy, o_wr_rdy}, 2'b01);
    tick;
    i_wr_req = 1'b0;
    check("byte_aw", {o_awaddr, o_awlen, o_awsize}, {32'h0000_0103, 8'd0, 3'd0});
    check("byte_w", {o_wdata, o_wstrb, o_wlast}, {32'h11223344, 4'b1000, 1'b1});
    i_awready = 1'b1; i_wready = 1'b1;
    tick;
    i_awready = 1'b0; i_wready = 1'b0;
    check("byte_resp", {o_bready, o_awvalid, o_wvalid, o_rd_rdy, o_arvalid}, 5'b10000);
    tick;
    check("raw_block", o_rd_rdy, 1'b0);
    i_rd_addr = 32'h0000_0200;
    #1;
    check("other_line", o_rd_rdy, RAW);
    i_rd_addr = 32'h0000_0100;
    i_bvalid = 1'b1;
    #1;
    check("raw_bvalid", o_rd_rdy, 1'b0);
    tick;
    i_bvalid = 1'b0;
    #1;
    check("raw_clear", {o_rd_rdy, o_wr_rdy}, 2'b11);
    tick;
    i_rd_req = 1'b0;
    ar_phase(32'h0000_0100, 8'd3, 3'd2, 0);
    r_beats(4, 9, 32'hC0000000);
    // reset during R_DATA and W_REQ
    rd(32'h0000_3000, 3'b100);
    ar_phase(32'h0000_3000, 8'd3, 3'd2, 0);
    i_wr_req = 1'b1; i_wr_type = 3'b100; i_wr_addr = 32'h0000_4000;
    tick;
    i_wr_req = 1'b0;
    check("mid_w", {o_awvalid, o_wvalid, o_rready}, 3'b111);
    i_rvalid = 1'b1; i_rdata = 32'h1; i_rlast = 1'b0;
    tick;
    i_rvalid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    check("mid_rst", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready, o_ret_valid, o_ret_last}, 8'd0);
    check("mid_rst_rdy", {o_rd_rdy, o_wr_rdy}, 2'b11);
    rd(32'h0000_1008, 3'b010);
    ar_phase(32'h0000_1008, 8'd0, 3'd2, 1);
    r_beats(1, 9, 32'h12345678);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_axi_bridge.md
# cache_axi_bridge

Converts the data cache's native memory request interface (single read channel, single write channel, 128-bit line writeback) into an AXI4 master. Sits directly downstream of the cache and upstream of the AXI interconnect/RAM slave. Supports one outstanding read and one outstanding write, with an independent FSM for each, and blocks reads that hit the line of a pending writeback.

## Interface
- RD_ID, 4'd0, ARID driven on every read
- WR_ID, 4'd1, AWID driven on every write
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rd_req  in  1  cache read request
- rd_type  in  3  000 byte, 001 half, 010 word, 100 line (4 words)
- rd_addr  in  32  read address
- rd_rdy  out  1  read request accepted when rd_req && rd_rdy
- ret_valid  out  1  return beat valid
- ret_last  out  2  [0] last beat, [1] error (RRESP != OKAY)
- ret_data  out  32  return beat data
- wr_req  in  1  cache write request
- wr_type  in  3  same encoding as rd_type
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe for non-line writes
- wr_data  in  128  write data; word k = bits [32k+31:32k]
- wr_rdy  out  1  write request accepted when wr_req && wr_rdy
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1; arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1; awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready  in  1
- bid/bresp/bvalid  in  4/2/1; bready  out  1

## Operation
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: rd_rdy = !hazard. On accept, latch addr/type, go R_ADDR.
  - R_ADDR: arvalid=1, fields from latch; on arready go R_DATA.
  - R_DATA: rready=1; ret_valid=rvalid, ret_data=rdata, ret_last={rresp!=0, rlast} (combinational pass-through); on rvalid && rlast go R_IDLE.
- Write FSM W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE: wr_rdy=1. On accept, latch addr/type/strb/data, clear aw_done and beat counter, go W_REQ.
  - W_REQ: awvalid=!aw_done; wvalid=!w_done; AW and W proceed independently, in either order or same cycle. wdata = word[beat]; wlast = (beat==awlen). Counter (2-bit) increments on wvalid && wready. Go W_RESP when AW and last W have both been accepted.
  - W_RESP: bready=1; on bvalid go W_IDLE. bresp is ignored.
- Field encoding: line → len 3, size 2, burst INCR, addr[3:0] forced to 0, wstrb 4'hF; non-line → len 0, size = rd/wr_type[1:0], addr unmodified, wstrb = latched wr_wstrb. burst is always 2'b01.
- Hazard: (write FSM != W_IDLE && rd_addr[31:4]==wr_addr_q[31:4]) || (wr_req && wr_rdy && rd_addr[31:4]==wr_addr[31:4]). Same-cycle read and write requests to the same line: the write is accepted and the read waits.

## Timing
- Reset values: arvalid, rready, awvalid, wvalid, bready, ret_valid = 0; ret_last = 0; both FSMs idle. rd_rdy = wr_rdy = 1 from the first cycle after reset (rd_rdy subject to hazard).
- Read: accept at edge N, arvalid high from N+1. First ret_valid appears in the same cycle as the first rvalid.
- Write: accept at edge N, awvalid/wvalid high from N+1. Minimum 4 W cycles for a line; wr_rdy rises the cycle after bvalid handshake.
- Valid signals hold stable with unchanged payload until their ready is sampled high.
- Reset mid-transaction: all FSMs return to idle at the next edge; the slave is reset by the same rst_n.

## Configuration
- BRIDGE_RAW_CHECK_EN defined: hazard is computed per line address as above.
- Not defined: hazard = (write FSM != W_IDLE) || (wr_req && wr_rdy), i.e. every read waits for any pending write to complete.

## Test plan
- Word read 0x0000_1004, arready after 2 cycles, single rdata 0xDEADBEEF rlast=1 → arlen=0, arsize=2, ret_valid one cycle with ret_data=0xDEADBEEF, ret_last=01.
- Line read 0x0000_2038 → araddr=0x0000_2030, arlen=3; 4 beats with rvalid gaps → exactly 4 ret_valid, ret_last[0] only on beat 4.
- Line write 0x1000_0040, data {D3,D2,D1,D0}, awready delayed 5 cycles after all W beats accepted → wdata D0..D3, wstrb F, wlast on D3, wr_rdy=1 the cycle after bvalid.
- Byte write 0x0000_0103 with wstrb 1000, then a line read of 0x0000_0100 while bvalid is withheld → rd_rdy=0 until the B handshake (macro on); a read of 0x0000_0200 is accepted immediately with the macro on and blocked with it off.
- rresp=2'b10 on line beat 2 → ret_last=10 on that beat; the FSM still completes at rlast.
- rst_n low for one cycle during R_DATA and W_REQ → all valids and readies at reset values next cycle; a new read is accepted afterwards.
